// File: rtl/etapa_fetch_pc_pkg.sv
// Shared encodings for the MIPS instruction-fetch stage: PC source select,
// FSM state codes and the default halt/bubble instruction words.
package etapa_fetch_pc_pkg;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_JR     = 2'b11
  } pc_src_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEF_HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_NOP_INSTR  = 32'h0000_0000;
  localparam int          JUMP_INDEX_W   = 26;

endpackage

// File: rtl/etapa_fetch_pc_if.sv
// Signal bundle between the fetch stage (slave) and its environment:
// hazard/redirect controls from ID, instruction memory data, and IF/ID outputs.
interface etapa_fetch_pc_if
  import etapa_fetch_pc_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int CNT_BITS = 32
);
  logic                    i_enable;
  logic                    i_stall;
  logic                    i_flush;
  logic [1:0]              i_pc_src;
  logic [NBITS-1:0]        i_branch_addr;
  logic [JUMP_INDEX_W-1:0] i_jump_index;
  logic [NBITS-1:0]        i_jr_addr;
  logic [NBITS-1:0]        i_instruction;
  logic [NBITS-1:0]        o_pc;
  logic [NBITS-1:0]        o_ifid_instruction;
  logic [NBITS-1:0]        o_ifid_pc_plus4;
  logic                    o_ifid_valid;
  logic                    o_halt;
  logic [CNT_BITS-1:0]     o_cycles;

  modport slave (
    input  i_enable, i_stall, i_flush, i_pc_src, i_branch_addr,
           i_jump_index, i_jr_addr, i_instruction,
    output o_pc, o_ifid_instruction, o_ifid_pc_plus4, o_ifid_valid,
           o_halt, o_cycles
  );

  modport master (
    output i_enable, i_stall, i_flush, i_pc_src, i_branch_addr,
           i_jump_index, i_jr_addr, i_instruction,
    input  o_pc, o_ifid_instruction, o_ifid_pc_plus4, o_ifid_valid,
           o_halt, o_cycles
  );
endinterface

// File: rtl/etapa_fetch_pc_pc_next_sel.sv
// Combinational next-PC selector: sequential, branch, J-format jump and
// jump-register targets, all forced to word alignment.
module etapa_fetch_pc_pc_next_sel
  import etapa_fetch_pc_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic [1:0]              pc_src,
  input  logic [NBITS-1:0]        pc_plus4,
  input  logic [NBITS-1:0]        ifid_pc_plus4,
  input  logic [NBITS-1:0]        branch_addr,
  input  logic [JUMP_INDEX_W-1:0] jump_index,
  input  logic [NBITS-1:0]        jr_addr,
  output logic [NBITS-1:0]        next_pc
);

  localparam logic [NBITS-1:0] ALIGN_MASK  = {{(NBITS-2){1'b1}}, 2'b00};
  localparam logic [NBITS-1:0] REGION_MASK = {{(NBITS-28){1'b1}}, 28'h0};

  logic [NBITS-1:0] jump_target;

  // Jump keeps the 256 MB region of the delay-slot address, i.e. IF/ID PC+4.
  assign jump_target = (ifid_pc_plus4 & REGION_MASK)
                     | {{(NBITS-28){1'b0}}, jump_index, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src_e'(pc_src))
      PC_SRC_SEQ:    next_pc = pc_plus4;
      PC_SRC_BRANCH: next_pc = branch_addr & ALIGN_MASK;
      PC_SRC_JUMP:   next_pc = jump_target;
      PC_SRC_JR:     next_pc = jr_addr & ALIGN_MASK;
      default:       next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/etapa_fetch_pc.sv
// MIPS instruction-fetch stage: PC register, IF/ID register, RUN/HALT FSM
// and saturating fetch-cycle counter for the debug unit.
module etapa_fetch_pc
  import etapa_fetch_pc_pkg::*;
#(
  parameter int               NBITS      = 32,
  parameter int               CNT_BITS   = 32,
  parameter logic [NBITS-1:0] HALT_INSTR = DEF_HALT_INSTR,
  parameter logic [NBITS-1:0] NOP_INSTR  = DEF_NOP_INSTR
) (
  input logic               i_clk,
  input logic               i_reset,
  etapa_fetch_pc_if.slave   bus
);

  logic [NBITS-1:0]    pc_p0;
  logic [NBITS-1:0]    pc_plus4_p0;
  logic [NBITS-1:0]    next_pc_p0;
  logic [NBITS-1:0]    ifid_instruction_p1;
  logic [NBITS-1:0]    ifid_pc_plus4_p1;
  logic                vld_p1;
  logic                halt_p0;
  logic [CNT_BITS-1:0] cycles_p0;
  fetch_state_e        state_p0;

  assign pc_plus4_p0 = pc_p0 + NBITS'(4);

  etapa_fetch_pc_pc_next_sel #(
    .NBITS (NBITS)
  ) u_pc_next_sel (
    .pc_src        (bus.i_pc_src),
    .pc_plus4      (pc_plus4_p0),
    .ifid_pc_plus4 (ifid_pc_plus4_p1),
    .branch_addr   (bus.i_branch_addr),
    .jump_index    (bus.i_jump_index),
    .jr_addr       (bus.i_jr_addr),
    .next_pc       (next_pc_p0)
  );

  // IF -> ID boundary: memory is combinational, so the word for pc_p0 is
  // captured on the same edge that the PC advances.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_p0               <= '0;
      ifid_instruction_p1 <= NOP_INSTR;
      ifid_pc_plus4_p1    <= '0;
      vld_p1              <= 1'b0;
      halt_p0             <= 1'b0;
      cycles_p0           <= '0;
      state_p0            <= ST_RUN;
    end else if (bus.i_enable) begin
      case (state_p0)
        ST_RUN: begin
          if (cycles_p0 != '1) cycles_p0 <= cycles_p0 + CNT_BITS'(1);
          if (bus.i_flush) begin
            pc_p0               <= next_pc_p0;
            ifid_instruction_p1 <= NOP_INSTR;
            vld_p1              <= 1'b0;
          end else if (bus.i_stall) begin
            pc_p0 <= pc_p0;
          end else if (bus.i_instruction == HALT_INSTR) begin
            // Halt word enters ID so the rest of the pipe can retire it.
            ifid_instruction_p1 <= bus.i_instruction;
            ifid_pc_plus4_p1    <= pc_plus4_p0;
            vld_p1              <= 1'b1;
            halt_p0             <= 1'b1;
            state_p0            <= ST_HALT;
          end else begin
            pc_p0               <= next_pc_p0;
            ifid_instruction_p1 <= bus.i_instruction;
            ifid_pc_plus4_p1    <= pc_plus4_p0;
            vld_p1              <= 1'b1;
          end
        end
        ST_HALT: begin
          ifid_instruction_p1 <= NOP_INSTR;
          vld_p1              <= 1'b0;
        end
        default: state_p0 <= ST_RUN;
      endcase
    end
  end

  assign bus.o_pc               = pc_p0;
  assign bus.o_ifid_instruction = ifid_instruction_p1;
  assign bus.o_ifid_pc_plus4    = ifid_pc_plus4_p1;
  assign bus.o_ifid_valid       = vld_p1;
  assign bus.o_halt             = halt_p0;
  assign bus.o_cycles           = cycles_p0;

endmodule

// File: tb/tb_etapa_fetch_pc.sv
// Scoreboard bench for etapa_fetch_pc: a driver issues directed vectors and
// queues hand-computed IF results; a monitor pops and compares after each edge.
module tb_etapa_fetch_pc;

  localparam logic [31:0] ADD_W  = 32'h0022_1820;
  localparam logic [31:0] SUB_W  = 32'h0022_1822;
  localparam logic [31:0] AND_W  = 32'h0022_1824;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_W  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [1:0]  src = 2'b00;
  logic [31:0] br = '0, jr = '0, instr = '0;
  logic [25:0] jidx = '0;

  always #5 clk = ~clk;

  etapa_fetch_pc_if #(.NBITS(32), .CNT_BITS(32)) bus ();
  etapa_fetch_pc_if #(.NBITS(32), .CNT_BITS(3))  bus_sat ();

  assign bus.i_enable          = en;
  assign bus.i_stall           = stall;
  assign bus.i_flush           = flush;
  assign bus.i_pc_src          = src;
  assign bus.i_branch_addr     = br;
  assign bus.i_jump_index      = jidx;
  assign bus.i_jr_addr         = jr;
  assign bus.i_instruction     = instr;
  assign bus_sat.i_enable      = en;
  assign bus_sat.i_stall       = stall;
  assign bus_sat.i_flush       = flush;
  assign bus_sat.i_pc_src      = src;
  assign bus_sat.i_branch_addr = br;
  assign bus_sat.i_jump_index  = jidx;
  assign bus_sat.i_jr_addr     = jr;
  assign bus_sat.i_instruction = instr;

  etapa_fetch_pc dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  etapa_fetch_pc #(.CNT_BITS(3)) dut_sat (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_sat)
  );

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] ii;
    logic [31:0] p4;
    logic        v;
    logic        h;
    logic [31:0] cyc;
    logic [2:0]  cyc_sat;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  task automatic chk(input string name, input int id,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  // Monitor: the stage updates every enabled edge, so each edge presents a result.
  exp_t e;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc",         e.id, bus.o_pc,               e.pc);
      chk("ifid_instr", e.id, bus.o_ifid_instruction, e.ii);
      chk("ifid_pc4",   e.id, bus.o_ifid_pc_plus4,    e.p4);
      chk("ifid_valid", e.id, {31'b0, bus.o_ifid_valid}, {31'b0, e.v});
      chk("halt",       e.id, {31'b0, bus.o_halt},       {31'b0, e.h});
      chk("cycles",     e.id, bus.o_cycles,           e.cyc);
      chk("cycles_sat", e.id, {29'b0, bus_sat.o_cycles}, {29'b0, e.cyc_sat});
    end
  end

  task automatic step(input logic r, input logic en_i, input logic st_i,
                      input logic fl_i, input logic [1:0] src_i,
                      input logic [31:0] br_i, input logic [25:0] j_i,
                      input logic [31:0] jr_i, input logic [31:0] ins_i,
                      input logic [31:0] epc, input logic [31:0] eii,
                      input logic [31:0] ep4, input logic ev, input logic eh,
                      input logic [31:0] ecyc);
    exp_t x;
    @(negedge clk);
    rst = r; en = en_i; stall = st_i; flush = fl_i; src = src_i;
    br = br_i; jidx = j_i; jr = jr_i; instr = ins_i;
    x.id = step_id; x.pc = epc; x.ii = eii; x.p4 = ep4; x.v = ev; x.h = eh;
    x.cyc = ecyc;
    x.cyc_sat = (ecyc > 32'd7) ? 3'd7 : ecyc[2:0];
    q.push_back(x);
    step_id++;
  endtask

  initial begin
    //    rst en st fl src  br            jidx   jr            instr
    //    exp: pc           ifid_instr ifid_pc4      v  h  cycles
    step(1, 1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,        ADD_W,
         32'h0,        NOP_W,  32'h0,        0, 0, 0);
    step(0, 1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,        ADD_W,
         32'h4,        ADD_W,  32'h4,        1, 0, 1);
    step(0, 1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,        SUB_W,
         32'h8,        SUB_W,  32'h8,        1, 0, 2);
    step(0, 0, 0, 1, 2'b01, 32'h100,      26'h0, 32'h0,        AND_W,
         32'h8,        SUB_W,  32'h8,        1, 0, 2);
    step(0, 1, 1, 0, 2'b00, 32'h0,        26'h0, 32'h0,        AND_W,
         32'h8,        SUB_W,  32'h8,        1, 0, 3);
    step(0, 1, 1, 0, 2'b00, 32'h0,        26'h0, 32'h0,        AND_W,
         32'h8,        SUB_W,  32'h8,        1, 0, 4);
    step(0, 1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,        AND_W,
         32'hC,        AND_W,  32'hC,        1, 0, 5);
    step(0, 1, 1, 0, 2'b00, 32'h0,        26'h0, 32'h0,        HALT_W,
         32'hC,        AND_W,  32'hC,        1, 0, 6);
    step(0, 1, 1, 1, 2'b01, 32'h3D,       26'h0, 32'h0,        HALT_W,
         32'h3C,       NOP_W,  32'hC,        0, 0, 7);
    step(0, 1, 0, 1, 2'b01, 32'h1000_000C, 26'h0, 32'h0,       NOP_W,
         32'h1000_000C, NOP_W, 32'hC,        0, 0, 8);
    step(0, 1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,        ADD_W,
         32'h1000_0010, ADD_W, 32'h1000_0010, 1, 0, 9);
    step(0, 1, 0, 1, 2'b10, 32'h0,        26'h8, 32'h0,        SUB_W,
         32'h1000_0020, NOP_W, 32'h1000_0010, 0, 0, 10);
    step(0, 1, 0, 1, 2'b11, 32'h0,        26'h0, 32'h47,       AND_W,
         32'h44,       NOP_W,  32'h1000_0010, 0, 0, 11);
    step(0, 1, 0, 1, 2'b01, 32'h14,       26'h0, 32'h0,        NOP_W,
         32'h14,       NOP_W,  32'h1000_0010, 0, 0, 12);
    step(0, 1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,        HALT_W,
         32'h14,       HALT_W, 32'h18,       1, 1, 13);
    step(0, 1, 1, 1, 2'b01, 32'h200,      26'h0, 32'h0,        ADD_W,
         32'h14,       NOP_W,  32'h18,       0, 1, 13);
    step(0, 0, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,        ADD_W,
         32'h14,       NOP_W,  32'h18,       0, 1, 13);
    step(1, 1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,        ADD_W,
         32'h0,        NOP_W,  32'h0,        0, 0, 0);
    step(0, 1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,        ADD_W,
         32'h4,        ADD_W,  32'h4,        1, 0, 1);
    step(0, 1, 0, 1, 2'b11, 32'h0,        26'h0, 32'hFFFF_FFFF, SUB_W,
         32'hFFFF_FFFC, NOP_W, 32'h4,        0, 0, 2);
    step(0, 1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,        SUB_W,
         32'h0,        SUB_W,  32'h0,        1, 0, 3);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results still pending, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
